branch_predict_unit: RTL and testbench
======================================

// Module: branch_predict_unit
// PURPOSE
//   Execute-stage branch resolver plus fetch-stage direction predictor for the RV32 core.
//   Evaluates all six RV32I conditions (BEQ/BNE/BLT/BGE/BLTU/BGEU) from funct3 and rs1/rs2.
//   Trains a PC-indexed table of 2-bit saturating counters and flags mispredictions.
//   Keeps saturating branch and mispredict statistics counters.
// PARAMETERS
//   XLEN         32    operand and PC width
//   BHT_ENTRIES  64    predictor table depth; power of 2, >= 2
//   PC_LSB       2     lowest PC bit used for the table index
//   CTR_INIT     2'b01 counter value after reset (weakly not-taken)
//   CNT_W        16    statistics counter width
// PORTS
//   clk            in   1      clock; all state updates on rising edge
//   rst_n          in   1      asynchronous active-low reset
//   pred_pc_i      in   XLEN   fetch PC to predict
//   pred_taken_o   out  1      predicted direction for pred_pc_i (combinational)
//   resolve_valid_i in  1      branch in execute this cycle
//   resolve_pc_i   in   XLEN   PC of the resolving branch
//   funct3_i       in   3      instruction bits [14:12]
//   rs1_i, rs2_i   in   XLEN   branch operands
//   pred_taken_i   in   1      prediction carried down the pipe with this branch
//   cond_o         out  6      {bgeu,bltu,bge,blt,bne,beq} one-hot-by-funct3, gated by valid
//   taken_o        out  1      actual branch outcome
//   mispredict_o   out  1      taken_o != pred_taken_i for a legal resolving branch
//   illegal_o      out  1      resolve_valid_i with funct3 = 3'b010 or 3'b011
//   stats_clr_i    in   1      synchronous clear of both statistics counters
//   branch_cnt_o   out  CNT_W  legal branches resolved
//   mispred_cnt_o  out  CNT_W  mispredictions
// BEHAVIOUR
//   - Index: IDX = pc[PC_LSB +: $clog2(BHT_ENTRIES)]; upper PC bits ignored (aliasing allowed).
//   - pred_taken_o = bht[IDX(pred_pc_i)][1]; pure read of registered table, zero latency.
//   - Conditions: eq = rs1==rs2; lt signed compare; ltu unsigned compare.
//     000 beq=eq, 001 bne=!eq, 100 blt=lt, 101 bge=!lt, 110 bltu=ltu, 111 bgeu=!ltu.
//   - cond_o, taken_o, mispredict_o, illegal_o combinational, all 0 when resolve_valid_i=0.
//   - illegal funct3: illegal_o=1, taken_o=0, mispredict_o=0, no table or stats update.
//   - Table update at rising edge when resolve_valid_i & legal: taken -> ctr=min(ctr+1,3);
//     not taken -> ctr=max(ctr-1,0). Saturated counters hold. New value visible next cycle.
//   - Same-cycle predict and update of one index: pred_taken_o returns the OLD value.
//   - Stats: branch_cnt +1 per legal resolve; mispred_cnt +1 per mispredict; each saturates
//     at all-ones (no wrap). stats_clr_i has priority over an increment in the same cycle.
//   - Reset (asserted any time, including mid-stream): every bht entry = CTR_INIT,
//     branch_cnt_o = mispred_cnt_o = 0; combinational outputs follow inputs. The first
//     rising edge after deassertion may update state normally.
//   - No handshake back-pressure: one resolve per cycle, always accepted.
// TESTING
//   1. Reset, then pred_pc_i=0x100 -> pred_taken_o=0; counters read 0.
//   2. BEQ rs1=rs2=5 at PC 0x100, pred_taken_i=0, x2 cycles -> taken_o=1, mispredict_o=1
//      both cycles; ctr 01->10->11; pred_taken_o(0x100)=1 from the 2nd cycle on; mispred_cnt=2.
//   3. BLT rs1=0xFFFFFFFF, rs2=1 -> taken_o=1; BLTU same operands -> taken_o=0;
//      BGE/BGEU give the complements; cond_o has exactly the matching bit set.
//   4. funct3=3'b010 with valid -> illegal_o=1, taken_o=0; bht and branch_cnt unchanged.
//   5. CNT_W=4: 20 legal resolves -> branch_cnt_o holds 15; stats_clr_i with a resolve
//      in the same cycle -> reads 0 next cycle.
//   6. PC 0x100 and 0x200 (BHT_ENTRIES=64) alias: train one taken, the other predicts taken;
//      assert rst_n low mid-sequence -> all entries back to CTR_INIT immediately.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Branch resolver and PC-indexed 2-bit direction predictor.
// Also keeps saturating branch and mispredict statistics.
module branch_predict_unit #(
    parameter int          XLEN        = 32,
    parameter int          BHT_ENTRIES = 64,
    parameter int          PC_LSB      = 2,
    parameter logic [1:0]  CTR_INIT    = 2'b01,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  pred_pc_i,
    output logic             pred_taken_o,
    input  logic             resolve_valid_i,
    input  logic [XLEN-1:0]  resolve_pc_i,
    input  logic [2:0]       funct3_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic             pred_taken_i,
    output logic [5:0]       cond_o,
    output logic             taken_o,
    output logic             mispredict_o,
    output logic             illegal_o,
    input  logic             stats_clr_i,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;
    logic             eq;
    logic             lt;
    logic             ltu;
    logic             legal;

    // Upper PC bits only alias into the table; fold them away here.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc_i, resolve_pc_i};

    assign pred_idx     = pred_pc_i[PC_LSB +: IDX_W];
    assign res_idx      = resolve_pc_i[PC_LSB +: IDX_W];
    assign pred_taken_o = bht[pred_idx][1];

    assign eq  = (rs1_i == rs2_i);
    assign lt  = ($signed(rs1_i) < $signed(rs2_i));
    assign ltu = (rs1_i < rs2_i);

    // Decode funct3 into the per-condition result vector.
    always_comb begin
        cond_o    = '0;
        illegal_o = 1'b0;
        if (resolve_valid_i) begin
            unique case (funct3_i)
                3'b000:  cond_o[0] = eq;
                3'b001:  cond_o[1] = ~eq;
                3'b100:  cond_o[2] = lt;
                3'b101:  cond_o[3] = ~lt;
                3'b110:  cond_o[4] = ltu;
                3'b111:  cond_o[5] = ~ltu;
                default: illegal_o = 1'b1;
            endcase
        end
    end

    assign taken_o      = |cond_o;
    assign legal        = resolve_valid_i & ~illegal_o;
    assign mispredict_o = legal & (taken_o != pred_taken_i);

    // Train the resolving branch's saturating counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= CTR_INIT;
            end
        end else if (legal) begin
            if (taken_o) begin
                if (bht[res_idx] != 2'b11) begin
                    bht[res_idx] <= bht[res_idx] + 2'd1;
                end
            end else begin
                if (bht[res_idx] != 2'b00) begin
                    bht[res_idx] <= bht[res_idx] - 2'd1;
                end
            end
        end
    end

    // Saturating statistics; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_o  <= '0;
            mispred_cnt_o <= '0;
        end else if (stats_clr_i) begin
            branch_cnt_o  <= '0;
            mispred_cnt_o <= '0;
        end else begin
            if (legal && (branch_cnt_o != '1)) begin
                branch_cnt_o <= branch_cnt_o + CNT_W'(1);
            end
            if (mispredict_o && (mispred_cnt_o != '1)) begin
                mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit.
// Expected responses come from an arithmetic reference model.
module tb_branch_predict_unit;

    localparam int         XLEN  = 32;
    localparam int         BHT   = 64;
    localparam int         PCL   = 2;
    localparam int         CW    = 4;
    localparam logic [1:0] CINIT = 2'b01;
    localparam int         CMAX  = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [XLEN-1:0] pred_pc = '0;
    logic            pred_taken_o;
    logic            rvalid = 1'b0;
    logic [XLEN-1:0] rpc = '0;
    logic [2:0]      funct3 = '0;
    logic [XLEN-1:0] rs1 = '0;
    logic [XLEN-1:0] rs2 = '0;
    logic            pt_in = 1'b0;
    logic [5:0]      cond_o;
    logic            taken_o;
    logic            misp_o;
    logic            ill_o;
    logic            clr = 1'b0;
    logic [CW-1:0]   bcnt_o;
    logic [CW-1:0]   mcnt_o;

    branch_predict_unit #(
        .XLEN(XLEN), .BHT_ENTRIES(BHT), .PC_LSB(PCL),
        .CTR_INIT(CINIT), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pred_pc_i(pred_pc), .pred_taken_o(pred_taken_o),
        .resolve_valid_i(rvalid), .resolve_pc_i(rpc),
        .funct3_i(funct3), .rs1_i(rs1), .rs2_i(rs2),
        .pred_taken_i(pt_in), .cond_o(cond_o), .taken_o(taken_o),
        .mispredict_o(misp_o), .illegal_o(ill_o),
        .stats_clr_i(clr), .branch_cnt_o(bcnt_o), .mispred_cnt_o(mcnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic       pred;
        logic [5:0] cond;
        logic       taken;
        logic       misp;
        logic       ill;
        int         bcnt;
        int         mcnt;
    } exp_t;

    exp_t q[$];
    int   model_bht[BHT];
    int   m_bcnt;
    int   m_mcnt;
    int   vectors = 0;
    int   miscompares = 0;
    int   next_id = 0;

    function automatic int idx(input logic [XLEN-1:0] pc);
        return int'((pc >> PCL) % BHT);
    endfunction

    function automatic void model_reset();
        foreach (model_bht[i]) model_bht[i] = int'(CINIT);
        m_bcnt = 0;
        m_mcnt = 0;
    endfunction

    function automatic void chk(input string n, input int id,
                                input int got, input int exp);
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s vec %0d got %0h expected %0h", n, id, got, exp);
        end
    endfunction

    // One clocked cycle of stimulus; expectation pushed before model update.
    task automatic step(input logic [XLEN-1:0] ppc, input logic rv,
                        input logic [XLEN-1:0] pc, input logic [2:0] f3,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic pt, input logic c);
        exp_t   e;
        int     f;
        int     sa;
        int     sb;
        longint ua;
        longint ub;
        bit     tk;
        bit     ill;
        bit     lg;
        int     k;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        pred_pc = ppc;
        rvalid  = rv;
        rpc     = pc;
        funct3  = f3;
        rs1     = a;
        rs2     = b;
        pt_in   = pt;
        clr     = c;
        f  = int'(f3);
        sa = a;
        sb = b;
        ua = a;
        ub = b;
        ill = rv && (f == 2 || f == 3);
        lg  = rv && !ill;
        tk  = 1'b0;
        if (lg) begin
            case (f)
                0: tk = (ua == ub);
                1: tk = (ua != ub);
                4: tk = (sa < sb);
                5: tk = (sa >= sb);
                6: tk = (ua < ub);
                default: tk = (ua >= ub);
            endcase
        end
        e.id    = next_id++;
        e.pred  = model_bht[idx(ppc)] >= 2;
        e.taken = tk;
        e.cond  = tk ? 6'(1 << (f < 2 ? f : f - 2)) : 6'd0;
        e.ill   = ill;
        e.misp  = lg && (tk != pt);
        e.bcnt  = m_bcnt;
        e.mcnt  = m_mcnt;
        q.push_back(e);
        if (lg) begin
            k = idx(pc);
            if (tk) model_bht[k] = (model_bht[k] + 1 > 3) ? 3 : model_bht[k] + 1;
            else    model_bht[k] = (model_bht[k] - 1 < 0) ? 0 : model_bht[k] - 1;
        end
        if (c) begin
            m_bcnt = 0;
            m_mcnt = 0;
        end else begin
            if (lg && m_bcnt < CMAX) m_bcnt++;
            if (e.misp && m_mcnt < CMAX) m_mcnt++;
        end
    endtask

    // Hold reset for one cycle mid-stream; state must snap back at once.
    task automatic reset_step(input logic [XLEN-1:0] ppc);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        rvalid  = 1'b0;
        clr     = 1'b0;
        pred_pc = ppc;
        model_reset();
        e.id    = next_id++;
        e.pred  = model_bht[idx(ppc)] >= 2;
        e.cond  = '0;
        e.taken = 1'b0;
        e.misp  = 1'b0;
        e.ill   = 1'b0;
        e.bcnt  = 0;
        e.mcnt  = 0;
        q.push_back(e);
    endtask

    // Monitor: compare every presented cycle against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                chk("pred_taken", e.id, int'(pred_taken_o), int'(e.pred));
                chk("cond",       e.id, int'(cond_o),       int'(e.cond));
                chk("taken",      e.id, int'(taken_o),      int'(e.taken));
                chk("mispredict", e.id, int'(misp_o),       int'(e.misp));
                chk("illegal",    e.id, int'(ill_o),        int'(e.ill));
                chk("branch_cnt", e.id, int'(bcnt_o),       e.bcnt);
                chk("mispred_cnt",e.id, int'(mcnt_o),       e.mcnt);
            end
        end
    end

    initial begin
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] ff;
        ff = 32'hFFFF_FFFF;
        model_reset();
        // reset state
        reset_step(32'h100);
        step(32'h100, 0, 0, 0, 0, 0, 0, 0);
        // BEQ taken twice, predicted not-taken
        step(32'h100, 1, 32'h100, 3'b000, 5, 5, 0, 0);
        step(32'h100, 1, 32'h100, 3'b000, 5, 5, 0, 0);
        step(32'h100, 0, 0, 0, 0, 0, 0, 0);
        // signed vs unsigned compares
        step(32'h0, 1, 32'h40, 3'b100, ff, 1, 1, 0);
        step(32'h0, 1, 32'h40, 3'b110, ff, 1, 1, 0);
        step(32'h0, 1, 32'h40, 3'b101, ff, 1, 0, 0);
        step(32'h0, 1, 32'h40, 3'b111, ff, 1, 0, 0);
        step(32'h0, 1, 32'h44, 3'b001, 7, 7, 1, 0);
        // illegal funct3
        step(32'h100, 1, 32'h100, 3'b010, 5, 5, 1, 0);
        step(32'h100, 1, 32'h100, 3'b011, 5, 5, 0, 0);
        step(32'h100, 0, 0, 0, 0, 0, 0, 0);
        // statistics saturation and clear priority
        for (int i = 0; i < 20; i++) begin
            step(32'h8, 1, 32'h8, 3'b000, i, 3, 0, 0);
        end
        step(32'h8, 1, 32'h8, 3'b000, 1, 1, 0, 1);
        step(32'h8, 0, 0, 0, 0, 0, 0, 0);
        // aliasing 0x100 / 0x200 and mid-stream reset
        reset_step(32'h100);
        step(32'h100, 1, 32'h200, 3'b000, 9, 9, 0, 0);
        step(32'h100, 1, 32'h200, 3'b000, 9, 9, 1, 0);
        step(32'h100, 0, 0, 0, 0, 0, 0, 0);
        reset_step(32'h100);
        step(32'h100, 0, 0, 0, 0, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset_step($urandom & 32'hF000_00FC);
            end else begin
                a = $urandom;
                case ($urandom_range(0, 3))
                    0:       b = a;
                    1:       b = a ^ (32'h1 << $urandom_range(0, 31));
                    2:       b = ~a;
                    default: b = $urandom;
                endcase
                step($urandom & 32'hF000_00FC, $urandom_range(0, 3) != 0,
                     $urandom & 32'hF000_00FC, 3'($urandom_range(0, 7)),
                     a, b, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 49) == 0);
            end
        end
        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
